// File: rtl/conv_encoder_r12.sv
// Rate-1/2 feed-forward convolutional encoder with framed tail flush.
// Ports: clk, RSTn (sync active-high reset), d_in_valid/d_in/d_in_ready
//   message bit handshake, d_out_valid/d_out/d_out_ready symbol handshake,
//   frame_done pulse aligned with the last tail symbol on d_out.
module conv_encoder_r12 #(
    parameter int             K        = 7,
    parameter logic [K-1:0]   G0       = 7'o171,
    parameter logic [K-1:0]   G1       = 7'o133,
    parameter int             MSG_LEN  = 512,
    parameter int             TAIL_LEN = 32
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       d_in_valid,
    input  logic       d_in,
    output logic       d_in_ready,
    output logic       d_out_valid,
    output logic [1:0] d_out,
    input  logic       d_out_ready,
    output logic       frame_done
);

    localparam int BW = $clog2(MSG_LEN);
    localparam int TW = $clog2(TAIL_LEN) + 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(MSG_LEN - 1);
    localparam logic [TW-1:0] LAST_TAIL = TW'(TAIL_LEN - 1);

    typedef enum logic {
        MSG  = 1'b0,
        TAIL = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic [TW-1:0] tail_cnt, tail_cnt_n;
    logic [K-2:0]  sr;
    logic          slot_free;
    logic          load;
    logic          u;
    logic          clr_sr;
    logic          done_n;
    logic [K-1:0]  w;
    logic [1:0]    sym;

    assign slot_free = !d_out_valid || d_out_ready;

    // Window is the current input followed by the K-1 history bits,
    // newest history bit at sr[K-2].
    assign w      = {u, sr};
    assign sym[0] = ^(w & G0);
    assign sym[1] = ^(w & G1);

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        tail_cnt_n = tail_cnt;
        load       = 1'b0;
        u          = 1'b0;
        clr_sr     = 1'b0;
        done_n     = 1'b0;
        d_in_ready = 1'b0;
        unique case (state)
            MSG: begin
                d_in_ready = slot_free;
                if (d_in_valid && slot_free) begin
                    load = 1'b1;
                    u    = d_in;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n  = '0;
                        tail_cnt_n = '0;
                        state_n    = TAIL;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            TAIL: begin
                // Tail symbols need no input; only backpressure stalls them.
                if (slot_free) begin
                    load = 1'b1;
                    if (tail_cnt == LAST_TAIL) begin
                        tail_cnt_n = '0;
                        done_n     = 1'b1;
                        clr_sr     = 1'b1;
                        state_n    = MSG;
                    end else begin
                        tail_cnt_n = tail_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = MSG;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RSTn) begin
            state       <= MSG;
            bit_cnt     <= '0;
            tail_cnt    <= '0;
            sr          <= '0;
            d_out       <= 2'b00;
            d_out_valid <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            tail_cnt   <= tail_cnt_n;
            frame_done <= done_n;
            if (load) begin
                // Clear on frame end keeps frames independent even
                // for tail lengths shorter than the memory.
                sr          <= clr_sr ? '0 : {u, sr[K-2:1]};
                d_out       <= sym;
                d_out_valid <= 1'b1;
            end else if (d_out_ready) begin
                d_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_r12.sv
// Testbench for conv_encoder_r12: reference convolution over whole
// frames compared against the consumed symbol stream.
module tb_conv_encoder_r12;

    localparam int MSG_LEN  = 512;
    localparam int TAIL_LEN = 32;
    localparam int FRAME    = MSG_LEN + TAIL_LEN;

    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic       d_in_valid = 1'b0;
    logic       d_in = 1'b0;
    logic       d_in_ready;
    logic       d_out_valid;
    logic [1:0] d_out;
    logic       d_out_ready = 1'b0;
    logic       frame_done;

    conv_encoder_r12 dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .d_in_valid (d_in_valid),
        .d_in       (d_in),
        .d_in_ready (d_in_ready),
        .d_out_valid(d_out_valid),
        .d_out      (d_out),
        .d_out_ready(d_out_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    bit         msg_q[$];
    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];
    int         fd_q[$];
    int         idx;
    int         stall_viol;
    int         bubbles;

    // Reference: symbol i is the XOR of generator-selected input bits
    // x[i], x[i-1], ..., x[i-6]; the frame input is message then zeros.
    function automatic void model_frame(input int base);
        logic [6:0] g0;
        logic [6:0] g1;
        g0 = 7'o171;
        g1 = 7'o133;
        for (int i = 0; i < FRAME; i++) begin
            logic s0;
            logic s1;
            s0 = 1'b0;
            s1 = 1'b0;
            for (int j = 0; j < 7; j++) begin
                int  t;
                bit  x;
                t = i - j;
                x = (t >= 0 && t < MSG_LEN) ? msg_q[base + t] : 1'b0;
                s0 ^= g0[6-j] & x;
                s1 ^= g1[6-j] & x;
            end
            exp_q.push_back({s1, s0});
        end
    endfunction

    task automatic rand_msg(input int nbits);
        for (int i = 0; i < nbits; i++) msg_q.push_back(1'($urandom));
    endtask

    task automatic clear_mon();
        got_q.delete();
        fd_q.delete();
        idx        = 0;
        stall_viol = 0;
        bubbles    = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        RSTn        = 1'b1;
        d_in_valid  = 1'b0;
        d_out_ready = 1'b0;
        @(posedge clk);
        #1;
        RSTn = 1'b0;
        clear_mon();
    endtask

    // Drives message bits and downstream ready, records consumed symbols.
    task automatic run(input int rdy_pct, input int vld_pct,
                       input int stop_syms, input int stop_acc,
                       input int max_cyc);
        bit         prev_stall;
        logic [1:0] prev_sym;
        bit         seen;
        prev_stall = 1'b0;
        prev_sym   = 2'b00;
        seen       = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk);
            #1;
            d_out_ready = ($urandom_range(99) < rdy_pct);
            if (idx < msg_q.size() && $urandom_range(99) < vld_pct) begin
                d_in_valid = 1'b1;
                d_in       = msg_q[idx];
            end else begin
                d_in_valid = 1'b0;
                d_in       = 1'($urandom);
            end
            @(negedge clk);
            if (prev_stall && (!d_out_valid || d_out !== prev_sym))
                stall_viol++;
            if (seen && !d_out_valid) bubbles++;
            if (frame_done) fd_q.push_back(got_q.size());
            prev_stall = d_out_valid && !d_out_ready;
            prev_sym   = d_out;
            if (d_out_valid) seen = 1'b1;
            if (d_in_valid && d_in_ready) idx++;
            if (d_out_valid && d_out_ready) got_q.push_back(d_out);
            if (got_q.size() >= stop_syms || idx >= stop_acc) break;
        end
        @(posedge clk);
        #1;
        d_in_valid  = 1'b0;
        d_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (d_out_valid !== 1'b0) begin
            n_errs++;
            $display("FAIL reset_valid: got %b want 0", d_out_valid);
        end
        n_checks++;
        if (d_out !== 2'b00) begin
            n_errs++;
            $display("FAIL reset_dout: got %b want 00", d_out);
        end
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_errs++;
            $display("FAIL reset_fd: got %b want 0", frame_done);
        end
        n_checks++;
        if (d_in_ready !== 1'b1) begin
            n_errs++;
            $display("FAIL reset_ready: got %b want 1", d_in_ready);
        end
    endtask

    task automatic test_all_zero();
        msg_q.delete();
        for (int i = 0; i < MSG_LEN; i++) msg_q.push_back(1'b0);
        do_reset();
        run(100, 100, FRAME, 1 << 30, 2000);
        n_checks++;
        if (got_q.size() !== FRAME) begin
            n_errs++;
            $display("FAIL zero_count: got %0d want %0d", got_q.size(), FRAME);
        end
        foreach (got_q[i]) begin
            n_checks++;
            if (got_q[i] !== 2'b00) begin
                n_errs++;
                $display("FAIL zero_sym[%0d]: got %b want 00", i, got_q[i]);
            end
        end
        n_checks++;
        if (bubbles !== 0) begin
            n_errs++;
            $display("FAIL zero_bubbles: got %0d want 0", bubbles);
        end
        n_checks++;
        if (fd_q.size() !== 1 || fd_q[0] !== FRAME - 1) begin
            n_errs++;
            $display("FAIL zero_fd: got n=%0d at=%0d want 1 at %0d",
                     fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1,
                     FRAME - 1);
        end
    endtask

    task automatic test_impulse();
        logic [1:0] imp [7];
        imp = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
        msg_q.delete();
        msg_q.push_back(1'b1);
        for (int i = 1; i < MSG_LEN; i++) msg_q.push_back(1'b0);
        do_reset();
        d_in_valid  = 1'b1;
        d_in        = 1'b1;
        d_out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin
            n_errs++;
            $display("FAIL imp_pre: valid=%b ready=%b want 0 1",
                     d_out_valid, d_in_ready);
        end
        idx = 1;
        run(100, 100, FRAME, 1 << 30, 2000);
        n_checks++;
        if (got_q.size() !== FRAME) begin
            n_errs++;
            $display("FAIL imp_count: got %0d want %0d", got_q.size(), FRAME);
        end
        n_checks++;
        if (bubbles !== 0) begin
            n_errs++;
            $display("FAIL imp_latency: bubbles %0d want 0", bubbles);
        end
        foreach (got_q[i]) begin
            logic [1:0] e;
            e = (i < 7) ? imp[i] : 2'b00;
            n_checks++;
            if (got_q[i] !== e) begin
                n_errs++;
                $display("FAIL imp_sym[%0d]: got %b want %b", i, got_q[i], e);
            end
        end
    endtask

    task automatic test_random();
        msg_q.delete();
        exp_q.delete();
        rand_msg(MSG_LEN);
        model_frame(0);
        do_reset();
        run(100, 100, FRAME, 1 << 30, 2000);
        n_checks++;
        if (got_q.size() !== FRAME) begin
            n_errs++;
            $display("FAIL rnd_count: got %0d want %0d", got_q.size(), FRAME);
        end
        foreach (got_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errs++;
                $display("FAIL rnd_sym[%0d]: got %b want %b",
                         i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (fd_q.size() !== 1 || fd_q[0] !== FRAME - 1) begin
            n_errs++;
            $display("FAIL rnd_fd: got n=%0d want 1 at %0d",
                     fd_q.size(), FRAME - 1);
        end
    endtask

    // Reuses the previous message and expected stream.
    task automatic test_stall();
        do_reset();
        run(50, 70, FRAME, 1 << 30, 8000);
        n_checks++;
        if (got_q.size() !== FRAME) begin
            n_errs++;
            $display("FAIL stall_count: got %0d want %0d",
                     got_q.size(), FRAME);
        end
        foreach (got_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errs++;
                $display("FAIL stall_sym[%0d]: got %b want %b",
                         i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (stall_viol !== 0) begin
            n_errs++;
            $display("FAIL stall_hold: got %0d changes want 0", stall_viol);
        end
        n_checks++;
        if (fd_q.size() !== 1 || fd_q[0] !== FRAME - 1) begin
            n_errs++;
            $display("FAIL stall_fd: got n=%0d want 1 at %0d",
                     fd_q.size(), FRAME - 1);
        end
    endtask

    task automatic test_mid_reset();
        msg_q.delete();
        rand_msg(MSG_LEN);
        do_reset();
        run(100, 100, 1 << 30, 200, 2000);
        RSTn = 1'b1;
        @(posedge clk);
        #1;
        RSTn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_out_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_errs++;
            $display("FAIL mrst_valid: valid=%b fd=%b want 0 0",
                     d_out_valid, frame_done);
        end
        n_checks++;
        if (d_in_ready !== 1'b1) begin
            n_errs++;
            $display("FAIL mrst_ready: got %b want 1", d_in_ready);
        end
        msg_q.delete();
        exp_q.delete();
        rand_msg(MSG_LEN);
        model_frame(0);
        clear_mon();
        run(100, 100, FRAME, 1 << 30, 2000);
        n_checks++;
        if (got_q.size() !== FRAME) begin
            n_errs++;
            $display("FAIL mrst_count: got %0d want %0d",
                     got_q.size(), FRAME);
        end
        foreach (got_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errs++;
                $display("FAIL mrst_sym[%0d]: got %b want %b",
                         i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        msg_q.delete();
        exp_q.delete();
        rand_msg(2 * MSG_LEN);
        model_frame(0);
        model_frame(MSG_LEN);
        do_reset();
        run(100, 100, 2 * FRAME, 1 << 30, 4000);
        n_checks++;
        if (got_q.size() !== 2 * FRAME) begin
            n_errs++;
            $display("FAIL b2b_count: got %0d want %0d",
                     got_q.size(), 2 * FRAME);
        end
        foreach (got_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_errs++;
                $display("FAIL b2b_sym[%0d]: got %b want %b",
                         i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (bubbles !== 0) begin
            n_errs++;
            $display("FAIL b2b_gap: got %0d bubbles want 0", bubbles);
        end
        n_checks++;
        if (fd_q.size() !== 2 || fd_q[0] !== FRAME - 1
            || fd_q[1] !== 2 * FRAME - 1) begin
            n_errs++;
            $display("FAIL b2b_fd: got n=%0d want 2 at %0d,%0d",
                     fd_q.size(), FRAME - 1, 2 * FRAME - 1);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_impulse();
        test_random();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
